// File: rtl/saved_lines_seq.sv
// Sequencer for the 3x3 line-buffer datapath: loads nine kernel weights into the
// weight shift chain, then streams one ROWS x LINES frame and flags complete windows.
module saved_lines_seq #(
    parameter int LINES = 16,
    parameter int ROWS  = 16,
    parameter int N     = 4,
    parameter int M     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         reload_w,
    input  logic         w_src_valid,
    input  logic [M-1:0] w_src_data,
    output logic         w_src_ready,
    input  logic         px_valid,
    input  logic [N-1:0] px_data,
    output logic         px_ready,
    output logic [N-1:0] d_in,
    output logic         en_in,
    output logic [M-1:0] w_in,
    output logic         w_conf,
    output logic         win_valid,
    output logic         win_last,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(LINES);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(LINES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          w_loaded;
    logic [3:0]    wcnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          w_acc;
    logic          px_acc;
    logic          wcnt_last;
    logic          frame_last;
    logic          win_tag;
    logic          win_tag_p0;
    logic          last_tag_p0;

    assign w_acc      = w_src_valid && w_src_ready;
    assign px_acc     = px_valid && px_ready;
    assign wcnt_last  = (wcnt == 4'd8);
    assign frame_last = (row == ROW_LAST) && (col == COL_LAST);
    // The window is complete once two full lines and two pixels precede this one.
    assign win_tag    = (row >= RW'(2)) && (col >= CW'(2));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        w_src_ready = 1'b0;
        px_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (reload_w || !w_loaded) ? WLOAD : STREAM;
            end
            WLOAD: begin
                w_src_ready = 1'b1;
                if (w_src_valid && wcnt_last) state_nxt = STREAM;
            end
            STREAM: begin
                px_ready = 1'b1;
                if (px_valid && frame_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_loaded    <= 1'b0;
            wcnt        <= 4'd0;
            col         <= '0;
            row         <= '0;
            w_in        <= '0;
            w_conf      <= 1'b0;
            d_in        <= '0;
            en_in       <= 1'b0;
            win_tag_p0  <= 1'b0;
            last_tag_p0 <= 1'b0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
        end else begin
            // Stage p0: handshake registered onto the datapath strobes and window tags
            w_conf      <= w_acc;
            en_in       <= px_acc;
            win_tag_p0  <= px_acc && win_tag;
            last_tag_p0 <= px_acc && frame_last;
            if (w_acc)  w_in <= w_src_data;
            if (px_acc) d_in <= px_data;

            // Stage p1: datapath has shifted, d_grp now shows the tagged window
            win_valid <= win_tag_p0;
            win_last  <= last_tag_p0;

            if (w_acc) begin
                if (wcnt_last) begin
                    wcnt     <= 4'd0;
                    w_loaded <= 1'b1;
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end

            if (px_acc) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) row <= '0;
                    else                 row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_saved_lines_seq.sv
// Directed bench for saved_lines_seq on a 4x4 frame: weight load, streaming with
// and without gaps, skipped reload, mid-frame reset and ignored stray inputs.
module tb_saved_lines_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       reload_w;
    logic       w_src_valid;
    logic [3:0] w_src_data;
    logic       w_src_ready;
    logic       px_valid;
    logic [3:0] px_data;
    logic       px_ready;
    logic [3:0] d_in;
    logic       en_in;
    logic [3:0] w_in;
    logic       w_conf;
    logic       win_valid;
    logic       win_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    saved_lines_seq #(.LINES(4), .ROWS(4), .N(4), .M(4)) dut (
        .clk(clk), .rst(rst), .start(start), .reload_w(reload_w),
        .w_src_valid(w_src_valid), .w_src_data(w_src_data), .w_src_ready(w_src_ready),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .d_in(d_in), .en_in(en_in), .w_in(w_in), .w_conf(w_conf),
        .win_valid(win_valid), .win_last(win_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_wready"}, 32'(w_src_ready), 0);
        chk({tag, "_pready"}, 32'(px_ready), 0);
        chk({tag, "_d_in"}, 32'(d_in), 0);
        chk({tag, "_en_in"}, 32'(en_in), 0);
        chk({tag, "_w_in"}, 32'(w_in), 0);
        chk({tag, "_w_conf"}, 32'(w_conf), 0);
        chk({tag, "_win_valid"}, 32'(win_valid), 0);
        chk({tag, "_win_last"}, 32'(win_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    function automatic logic is_win(input int q);
        return (q == 10) || (q == 11) || (q == 14) || (q == 15);
    endfunction

    initial begin
        int   wins;
        int   p;
        int   k;
        int   cyc;
        int   nconf;
        logic v;
        logic tagq;
        logic lastq;
        logic [3:0] lastd;
        logic [3:0] lastw;

        rst = 1'b1; start = 1'b0; reload_w = 1'b0;
        w_src_valid = 1'b0; w_src_data = 4'd0; px_valid = 1'b0; px_data = 4'd0;
        tick;
        tick;
        chk_idle_zero("reset");
        rst = 1'b0;

        // stray pixel in IDLE is not accepted
        px_valid = 1'b1; px_data = 4'd7;
        tick;
        chk("idle_pready", 32'(px_ready), 0);
        chk("idle_en_in", 32'(en_in), 0);
        chk("idle_d_in", 32'(d_in), 0);
        chk("idle_busy", 32'(busy), 0);
        px_valid = 1'b0;

        // first start without reload still loads weights
        start = 1'b1; reload_w = 1'b0;
        tick;
        start = 1'b0;
        chk("wload_wready", 32'(w_src_ready), 1);
        chk("wload_pready", 32'(px_ready), 0);
        chk("wload_busy", 32'(busy), 1);
        for (int i = 1; i <= 9; i++) begin
            w_src_valid = 1'b1; w_src_data = 4'(i);
            tick;
            chk("w_conf_pulse", 32'(w_conf), 1);
            chk("w_in_seq", 32'(w_in), 32'(i));
            chk("w_en_in", 32'(en_in), 0);
        end
        w_src_valid = 1'b0;
        chk("stream_pready", 32'(px_ready), 1);
        chk("stream_wready", 32'(w_src_ready), 0);

        // full-throughput frame
        wins = 0;
        for (int q = 0; q < 16; q++) begin
            px_valid = 1'b1; px_data = 4'(q);
            tick;
            chk("f1_en_in", 32'(en_in), 1);
            chk("f1_d_in", 32'(d_in), 32'(q));
            chk("f1_w_conf", 32'(w_conf), 0);
            chk("f1_win_valid", 32'(win_valid), 32'(is_win(q - 1)));
            chk("f1_win_last", 32'(win_last), 0);
            chk("f1_done", 32'(done), 32'(q == 15));
            wins += int'(win_valid);
        end
        px_valid = 1'b0;
        tick;
        chk("f1_tail_win_valid", 32'(win_valid), 1);
        chk("f1_tail_win_last", 32'(win_last), 1);
        chk("f1_tail_done", 32'(done), 0);
        chk("f1_tail_busy", 32'(busy), 0);
        chk("f1_tail_en_in", 32'(en_in), 0);
        chk("f1_tail_d_in", 32'(d_in), 15);
        wins += int'(win_valid);
        chk("f1_windows", 32'(wins), 4);

        // second frame skips weight load, random pixel gaps, stray start mid-stream
        start = 1'b1; reload_w = 1'b0;
        tick;
        start = 1'b0;
        chk("f2_direct_pready", 32'(px_ready), 1);
        chk("f2_direct_wready", 32'(w_src_ready), 0);
        p = 0; cyc = 0; wins = 0; tagq = 1'b0; lastq = 1'b0; lastd = 4'd15;
        while (p < 16 && cyc < 200) begin
            v = 1'($urandom_range(0, 1));
            px_valid = v;
            px_data  = v ? 4'(p) : 4'(p ^ 5);
            start    = (cyc == 3);
            tick;
            cyc++;
            chk("f2_en_in", 32'(en_in), 32'(v));
            chk("f2_d_in", 32'(d_in), v ? 32'(p) : 32'(lastd));
            chk("f2_w_conf", 32'(w_conf), 0);
            chk("f2_win_valid", 32'(win_valid), 32'(tagq));
            chk("f2_win_last", 32'(win_last), 32'(lastq));
            wins += int'(win_valid);
            tagq  = v && is_win(p);
            lastq = v && (p == 15);
            if (v) begin
                lastd = 4'(p);
                p++;
            end
        end
        start = 1'b0; px_valid = 1'b0;
        chk("f2_bound", 32'(p), 16);
        chk("f2_done", 32'(done), 1);
        tick;
        chk("f2_tail_win_valid", 32'(win_valid), 32'(tagq));
        chk("f2_tail_win_last", 32'(win_last), 32'(lastq));
        chk("f2_tail_done", 32'(done), 0);
        chk("f2_tail_busy", 32'(busy), 0);
        wins += int'(win_valid);
        chk("f2_windows", 32'(wins), 4);

        // forced reload with random weight gaps
        start = 1'b1; reload_w = 1'b1;
        tick;
        start = 1'b0; reload_w = 1'b0;
        chk("f3_wready", 32'(w_src_ready), 1);
        chk("f3_pready", 32'(px_ready), 0);
        k = 1; cyc = 0; nconf = 0; lastw = 4'd9;
        while (k <= 9 && cyc < 200) begin
            v = 1'($urandom_range(0, 1));
            w_src_valid = v;
            w_src_data  = v ? 4'(k) : 4'hE;
            tick;
            cyc++;
            chk("f3_w_conf", 32'(w_conf), 32'(v));
            chk("f3_w_in", 32'(w_in), v ? 32'(k) : 32'(lastw));
            chk("f3_en_in", 32'(en_in), 0);
            nconf += int'(w_conf);
            if (v) begin
                lastw = 4'(k);
                k++;
            end
        end
        w_src_valid = 1'b0;
        chk("f3_bound", 32'(k), 10);
        chk("f3_nconf", 32'(nconf), 9);
        chk("f3_stream_pready", 32'(px_ready), 1);

        // reset after six pixels
        for (int q = 0; q < 6; q++) begin
            px_valid = 1'b1; px_data = 4'(q + 1);
            tick;
            chk("f3_en_in", 32'(en_in), 1);
        end
        px_valid = 1'b0; rst = 1'b1;
        tick;
        chk_idle_zero("midrst");
        rst = 1'b0;
        start = 1'b1; reload_w = 1'b0;
        tick;
        start = 1'b0;
        chk("postrst_wload_wready", 32'(w_src_ready), 1);
        chk("postrst_pready", 32'(px_ready), 0);
        chk("postrst_busy", 32'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/saved_lines_seq.md
# saved_lines_seq

Sequencer for the 3x3 window line-buffer datapath in the PE. It loads the nine kernel weights through the datapath's weight shift chain and then streams one ROWS x LINES input frame into the data chain. It tracks the pixel row and column and flags every cycle in which the datapath's 3x3 data group holds a complete, in-frame window. It sits between the weight/pixel sources and the line-buffer datapath, and drives the datapath's `d_in`, `en_in`, `w_in` and `w_conf` inputs.

## Interface
- `LINES`, 16: pixels per frame line; must be ≥ 3.
- `ROWS`, 16: lines per frame; must be ≥ 3.
- `N`, 4: pixel width.
- `M`, 4: weight width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin one frame; sampled only in IDLE.
- `reload_w`  in  1: sampled with `start`; 1 forces a weight load.
- `w_src_valid`  in  1: weight word available.
- `w_src_data`  in  M: weight word.
- `w_src_ready`  out  1: weight accept; a transfer occurs when valid & ready.
- `px_valid`  in  1: pixel available.
- `px_data`  in  N: pixel.
- `px_ready`  out  1: pixel accept; a transfer occurs when valid & ready.
- `d_in`  out  N: to datapath, registered.
- `en_in`  out  1: to datapath, registered data-shift strobe.
- `w_in`  out  M: to datapath, registered.
- `w_conf`  out  1: to datapath, registered weight-shift strobe.
- `win_valid`  out  1: datapath `d_grp` holds a complete window this cycle.
- `win_last`  out  1: with `win_valid`, marks the final window of the frame.
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle end-of-frame pulse.

## Operation
- States: IDLE, WLOAD, STREAM, DONE. Reset puts the block in IDLE with every output 0, all counters 0 and the `w_loaded` flag 0.
- IDLE:
  - With `start`=1 and (`reload_w`=1 or `w_loaded`=0) → WLOAD.
  - With `start`=1 and `reload_w`=0 and `w_loaded`=1 → STREAM.
  - With `start`=0 → stay in IDLE.
- WLOAD:
  - `w_src_ready` = 1, combinationally from state.
  - Each accepted weight registers `w_in` ← `w_src_data` and `w_conf` ← 1; otherwise `w_conf` ← 0 and `w_in` holds.
  - `wcnt` runs 0..8. The accept at `wcnt`=8 sets `w_loaded`, clears `wcnt` and moves to STREAM.
  - Exactly nine `w_conf` pulses per load. The first weight supplied ends at datapath position 3_3, the last at 1_1.
- STREAM:
  - `px_ready` = 1, combinationally from state.
  - Each accepted pixel registers `d_in` ← `px_data` and `en_in` ← 1; otherwise `en_in` ← 0 and `d_in` holds.
  - `col` counts 0..LINES-1. When it wraps to 0, `row` increments 0..ROWS-1.
  - The accept at `row`=ROWS-1, `col`=LINES-1 clears both counters and moves to DONE.
- Window flag:
  - An accept with `row` ≥ 2 and `col` ≥ 2 (counter values before the update) is tagged.
  - The tag is delayed through `en_in`'s register, then through one further register, to drive `win_valid`.
  - `win_last` follows the same path, tagged only for the final pixel.
  - Per frame, `win_valid` pulses (ROWS-2)*(LINES-2) times.
- DONE: `done` = 1 for one cycle, then → IDLE. `win_valid` and `win_last` for the final pixel may still be in flight and must complete.
- `start` outside IDLE is ignored. `w_src_valid` outside WLOAD and `px_valid` outside STREAM are ignored; `w_src_ready` and `px_ready` are 0 there.
- Reset mid-operation clears the state to IDLE and clears `w_loaded`, counters, pipeline tags and all outputs on the next edge. Data already in the datapath registers is not cleared.
- Counter widths: `$clog2(LINES)`, `$clog2(ROWS)` and 4 bits for `wcnt`. No other arithmetic.

## Timing
- `start` at edge k → state WLOAD/STREAM at k+1; ready is high in cycle k+1.
- Handshake accepted at edge t → `w_conf`/`en_in` high in cycle t+1, so the datapath shifts at edge t+1.
- `win_valid` is high in cycle t+2, i.e. the cycle after the datapath shift, when `d_grp` shows the new window.
- Final pixel accept at edge t → DONE in cycle t+1; `done` high in t+1; IDLE at t+2; `win_valid`/`win_last` high in t+2.
- A new `start` is possible in cycle t+2. Back-to-back frames are allowed, but `win_valid` of the previous frame must not be lost.
- `en_in` and `w_conf` are never high in the same cycle.
- Full throughput: one pixel or weight per cycle while the source holds valid.

## Test plan
- Reset then `start`=1, `reload_w`=0 with LINES=4, ROWS=4 → WLOAD entered because `w_loaded`=0; weights 1..9 → nine consecutive `w_conf` pulses, `w_in` sequence 1..9, then STREAM.
- Stream pixels 0..15 with `px_valid` held at 1 → 16 `en_in` pulses; `win_valid` high exactly 4 times, 2 cycles after accepting pixels 10, 11, 14, 15; `win_last` only with the last; `done` one cycle after accepting pixel 15.
- Second `start` with `reload_w`=0 → IDLE goes directly to STREAM; no `w_conf`.
- Random `px_valid`/`w_src_valid` gaps → strobes only on transfers, with the same 4 windows and 9 weight shifts; `d_in` holds during gaps.
- `rst` asserted after 6 pixels → next cycle IDLE, all outputs 0, `w_loaded`=0; the next `start` with `reload_w`=0 still enters WLOAD.
- `start` pulsed in STREAM and stray `px_valid` in IDLE → no effect; `px_ready`=0 in IDLE.
